// File: rtl/region_pkg.sv
// Shared types for the region event decoder: region index encoding,
// per-strobe classification and the acceptance FSM state encoding.
package region_pkg;

  typedef enum logic [1:0] {
    REG_RED    = 2'd0,
    REG_GREEN  = 2'd1,
    REG_YELLOW = 2'd2,
    REG_BLUE   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    CLS_NONE     = 2'd0,
    CLS_VALID    = 2'd1,
    CLS_CONFLICT = 2'd2
  } class_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // No votes -> NONE, exactly one vote -> VALID, several votes -> CONFLICT.
  function automatic class_e classify(input logic [3:0] votes);
    if (votes == 4'b0000)
      return CLS_NONE;
    else if ((votes & (votes - 4'd1)) == 4'b0000)
      return CLS_VALID;
    else
      return CLS_CONFLICT;
  endfunction

  // Index of the single set bit; only meaningful when classify() is VALID.
  function automatic region_e region_index(input logic [3:0] votes);
    case (votes)
      4'b0010: return REG_GREEN;
      4'b0100: return REG_YELLOW;
      4'b1000: return REG_BLUE;
      default: return REG_RED;
    endcase
  endfunction

endpackage

// File: rtl/region_event_fifo.sv
// Event queue for the region decoder: power-of-two depth, 2-bit entries,
// simultaneous push/pop, and a saturating counter of pushes lost to a full queue.
module region_event_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       rst_n,
  input  logic       push,
  input  logic [1:0] push_data,
  input  logic       pop_ready,
  output logic       out_valid,
  output logic [1:0] out_data,
  output logic       full,
  output logic [7:0] drop_count
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [1:0]    mem [DEPTH];
  logic          empty;
  logic          pop;
  logic          wr_ok;
  logic          drop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop       = !empty && pop_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign wr_ok     = push && (!full || pop);
  assign drop      = push && full && !pop;
  assign out_valid = !empty;
  assign out_data  = empty ? 2'd0 : mem[rd_ptr[AW-1:0]];

  // Pointer and drop-counter update.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      drop_count <= 8'd0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
    end
  end

  // Storage write; contents are don't-care while the slot is empty.
  always_ff @(posedge PCLK) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/region_event_decoder.sv
// Region event decoder: debounces one-hot region votes sampled on `en`
// strobes and queues one event each time a new region is accepted.
// Optional feature macro REGION_HOLD_EN: when defined a region must persist
// for HOLD_FRAMES strobes; when undefined the first valid strobe accepts.
//
// Handshake: evt_valid means the head entry is present on evt_code and stays
// unchanged until consumed; an entry is consumed on every rising PCLK edge
// where evt_valid and evt_ready are both 1. There is no back-pressure on en.
module region_event_decoder
  import region_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int HOLD_FRAMES = 3
) (
  input  logic       PCLK,
  input  logic       rst_n,
  input  logic       en,
  input  logic [3:0] green_region,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  output logic       fifo_full,
  output logic [7:0] drop_count,
  output logic [1:0] dbg_state
);

`ifdef REGION_HOLD_EN
  localparam int EFF_HOLD = HOLD_FRAMES;
`else
  localparam int EFF_HOLD = 1;
`endif
  localparam logic [4:0] HOLD_W = 5'(EFF_HOLD);

  state_e     state_q, state_d;
  region_e    cand_q, cand_d;
  logic [3:0] hold_q, hold_d;
  logic       lock_vld_q, lock_vld_d;
  region_e    lock_q, lock_d;
  logic       accept;
  logic       push_q;
  region_e    push_code_q;

  class_e     cls;
  region_e    idx;
  logic [4:0] hold_inc;

  assign cls       = classify(green_region);
  assign idx       = region_index(green_region);
  assign hold_inc  = {1'b0, hold_q} + 5'd1;
  assign dbg_state = state_q;

  // Acceptance FSM registers plus the one-cycle push stage into the queue.
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cand_q      <= REG_RED;
      hold_q      <= 4'd0;
      lock_vld_q  <= 1'b0;
      lock_q      <= REG_RED;
      push_q      <= 1'b0;
      push_code_q <= REG_RED;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      hold_q      <= hold_d;
      lock_vld_q  <= lock_vld_d;
      lock_q      <= lock_d;
      push_q      <= accept;
      push_code_q <= lock_d;
    end
  end

  // Next-state: NONE unlocks, CONFLICT abandons tracking, VALID counts/accepts.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    hold_d     = hold_q;
    lock_vld_d = lock_vld_q;
    lock_d     = lock_q;
    accept     = 1'b0;
    if (en) begin
      case (cls)
        CLS_NONE: begin
          state_d    = ST_IDLE;
          lock_vld_d = 1'b0;
          hold_d     = 4'd0;
        end
        CLS_CONFLICT: begin
          hold_d  = 4'd0;
          state_d = lock_vld_q ? ST_LOCKED : ST_IDLE;
        end
        default: begin
          if (state_q == ST_TRACK && idx == cand_q) begin
            if (hold_inc >= HOLD_W) begin
              state_d    = ST_LOCKED;
              lock_vld_d = 1'b1;
              lock_d     = idx;
              hold_d     = 4'd0;
              accept     = 1'b1;
            end else begin
              hold_d = hold_inc[3:0];
            end
          end else if (state_q == ST_LOCKED && idx == lock_q) begin
            state_d = ST_LOCKED;
          end else begin
            // New candidate; with a hold of one it is accepted on the spot.
            cand_d = idx;
            if (5'd1 >= HOLD_W) begin
              state_d    = ST_LOCKED;
              lock_vld_d = 1'b1;
              lock_d     = idx;
              hold_d     = 4'd0;
              accept     = 1'b1;
            end else begin
              state_d = ST_TRACK;
              hold_d  = 4'd1;
            end
          end
        end
      endcase
    end
  end

  region_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .PCLK      (PCLK),
    .rst_n     (rst_n),
    .push      (push_q),
    .push_data (push_code_q),
    .pop_ready (evt_ready),
    .out_valid (evt_valid),
    .out_data  (evt_code),
    .full      (fifo_full),
    .drop_count(drop_count)
  );

endmodule

// File: tb/tb_region_event_decoder.sv
// Bench for region_event_decoder: event-level reference model, per-cycle
// compare on the falling edge, directed scenarios with literal expectations.
module tb_region_event_decoder;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
`ifdef REGION_HOLD_EN
  localparam int H = HOLD;
`else
  localparam int H = 1;
`endif

  // ---------------- clock / reset ----------------
  logic       PCLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] green_region = 4'd0;
  logic       evt_ready = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       fifo_full;
  logic [7:0] drop_count;
  logic [1:0] dbg_state;

  always #5 PCLK = ~PCLK;

  region_event_decoder #(
    .FIFO_DEPTH (DEPTH),
    .HOLD_FRAMES(HOLD)
  ) dut (
    .PCLK        (PCLK),
    .rst_n       (rst_n),
    .en          (en),
    .green_region(green_region),
    .evt_ready   (evt_ready),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .fifo_full   (fifo_full),
    .drop_count  (drop_count),
    .dbg_state   (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Region bookkeeping in plain integers (-1 = none), expected queue of codes.
  logic [1:0] exp_q[$];
  int         m_lock = -1;
  int         m_cand = -1;
  int         m_cnt  = 0;
  int         m_drop = 0;
  bit         m_pend = 1'b0;
  logic [1:0] m_pend_code = 2'd0;

  task automatic model_accept(input int i);
    m_lock      = i;
    m_cand      = -1;
    m_cnt       = 0;
    m_pend      = 1'b1;
    m_pend_code = 2'(i);
  endtask

  task automatic model_strobe(input logic [3:0] v);
    int n;
    int i;
    n = $countones(v);
    i = 0;
    for (int b = 0; b < 4; b++) if (v[b]) i = b;
    if (n == 0) begin
      m_lock = -1; m_cand = -1; m_cnt = 0;
    end else if (n > 1) begin
      m_cand = -1; m_cnt = 0;
    end else if (m_cand == i) begin
      m_cnt++;
      if (m_cnt >= H) model_accept(i);
    end else if (m_cand < 0 && m_lock == i) begin
      // already accepted, nothing new
    end else begin
      m_cand = i; m_cnt = 1;
      if (m_cnt >= H) model_accept(i);
    end
  endtask

  always @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_lock = -1; m_cand = -1; m_cnt = 0; m_drop = 0; m_pend = 1'b0;
    end else begin
      if (exp_q.size() > 0 && evt_ready) void'(exp_q.pop_front());
      if (m_pend) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(m_pend_code);
        else if (m_drop < 255) m_drop++;
      end
      m_pend = 1'b0;
      if (en) model_strobe(green_region);
    end
  end

  // ---------------- scoreboard / compare ----------------
  int         seen_n = 0;
  logic [1:0] seen_q[$];

  always @(negedge PCLK) begin
    if (chk_on) begin
      check("evt_valid", int'(evt_valid), int'(exp_q.size() > 0));
      if (exp_q.size() > 0) check("evt_code", int'(evt_code), int'(exp_q[0]));
      check("fifo_full", int'(fifo_full), int'(exp_q.size() == DEPTH));
      check("drop_count", int'(drop_count), m_drop);
      if (evt_valid && evt_ready) begin
        seen_n++;
        seen_q.push_back(evt_code);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic strobe(input logic [3:0] v);
    @(posedge PCLK); #1;
    en = 1'b1; green_region = v;
    @(posedge PCLK); #1;
    en = 1'b0; green_region = 4'hF;  // must be ignored while en=0
  endtask

  task automatic hold(input logic [3:0] v);
    repeat (H) strobe(v);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // ---------------- directed scenarios ----------------
  int base;

  initial begin
    repeat (2) @(posedge PCLK);
    #1 chk_on = 1'b1;
    @(negedge PCLK);
    check("rst_valid", int'(evt_valid), 0);
    check("rst_full", int'(fifo_full), 0);
    check("rst_drop", int'(drop_count), 0);
    check("rst_code", int'(evt_code), 0);
    @(posedge PCLK); #1 rst_n = 1'b1;

    // Three green strobes with ready high: one event, code 1.
    evt_ready = 1'b1;
    base = seen_n;
    repeat (3) strobe(4'b0010);
    @(negedge PCLK);
    check("t1_valid_before", int'(evt_valid), 0);
    @(negedge PCLK);
    check("t1_valid_after", int'(evt_valid), int'(H == 3));
    idle(3);
    check("t1_events", seen_n - base, 1);
    check("t1_code", int'(seen_q[seen_q.size()-1]), 1);

    // Green interrupted by yellow.
    strobe(4'b0000);
    base = seen_n;
    strobe(4'b0010); strobe(4'b0010);
    strobe(4'b0100); strobe(4'b0100); strobe(4'b0100);
    idle(4);
    check("t2_events", seen_n - base, (H <= 2) ? 2 : 1);
    check("t2_code", int'(seen_q[seen_q.size()-1]), 2);

    // Red, NONE, red again: second red event.
    strobe(4'b0000);
    base = seen_n;
    hold(4'b0001); strobe(4'b0000); hold(4'b0001);
    idle(4);
    check("t3_events", seen_n - base, 2);
    check("t3_code", int'(seen_q[seen_q.size()-1]), 0);

    // Six accepted changes into a depth-4 queue with ready low.
    strobe(4'b0000);
    idle(3);
    evt_ready = 1'b0;
    hold(4'b0001); hold(4'b0010); hold(4'b0100);
    hold(4'b1000); hold(4'b0001); hold(4'b0010);
    idle(3);
    check("t4_full", int'(fifo_full), 1);
    check("t4_drop", int'(drop_count), 2);
    base = seen_n;
    evt_ready = 1'b1;
    idle(6);
    check("t4_drained", seen_n - base, 4);
    for (int k = 0; k < 4; k++)
      check("t4_order", int'(seen_q[seen_q.size()-4+k]), k);

    // Conflict while tracking blue from a red lock.
    strobe(4'b0000);
    hold(4'b0001);
    idle(3);
    base = seen_n;
    strobe(4'b1000); strobe(4'b0110); strobe(4'b0001); strobe(4'b1000);
    idle(4);
    check("t5_events", seen_n - base, (H == 1) ? 3 : 0);

    // Reset with two events queued.
    evt_ready = 1'b0;
    strobe(4'b0000);
    hold(4'b0001); hold(4'b0010);
    idle(3);
    check("t6_queued", int'(evt_valid), 1);
    @(posedge PCLK); #1 rst_n = 1'b0;
    @(negedge PCLK);
    check("t6_rst_valid", int'(evt_valid), 0);
    check("t6_rst_drop", int'(drop_count), 0);
    @(posedge PCLK); #1 rst_n = 1'b1;
    idle(5);
    check("t6_no_event", int'(evt_valid), 0);
    hold(4'b0100);
    idle(2);
    check("t6_new_valid", int'(evt_valid), 1);
    check("t6_new_code", int'(evt_code), 2);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/region_event_decoder.md
REGION_EVENT_DECODER -- requirements
Module: region_event_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning event queue depth (power of two, 2..16).
REQ-002 SHALL have parameter HOLD_FRAMES, default 3, meaning consecutive `en` strobes a region must persist before acceptance (1..15).
REQ-003 SHALL have port PCLK  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  one-cycle strobe, green_region valid.
REQ-006 SHALL have port green_region  input  4  region votes: bit0 red, bit1 green, bit2 yellow, bit3 blue.
REQ-007 SHALL have port evt_ready  input  1  consumer accepts head event.
REQ-008 SHALL have port evt_valid  output  1  head event available.
REQ-009 SHALL have port evt_code  output  2  head event region index (0 red, 1 green, 2 yellow, 3 blue).
REQ-010 SHALL have port fifo_full  output  1  queue holds FIFO_DEPTH events.
REQ-011 SHALL have port drop_count  output  8  events lost to full queue, saturating.

Function
REQ-012 SHALL classify green_region only on cycles with en=1: exactly one bit set -> VALID(index); all zero -> NONE; two or more set -> CONFLICT.
REQ-013 SHALL ignore green_region entirely when en=0.
REQ-014 SHALL implement FSM IDLE/TRACK/LOCKED: IDLE = no accepted region; TRACK = candidate counting; LOCKED = region accepted.
REQ-015 SHALL, on VALID(i) in IDLE or on VALID(i) with i != locked region in LOCKED, load candidate=i, hold_cnt=1, enter TRACK.
REQ-016 SHALL, in TRACK on VALID(candidate), increment hold_cnt; when hold_cnt reaches HOLD_FRAMES, enter LOCKED with locked region=candidate and issue one push of candidate.
REQ-017 SHALL, in TRACK on VALID(j != candidate), restart with candidate=j, hold_cnt=1.
REQ-018 SHALL, on NONE in any state, enter IDLE and clear locked region, so re-entering the same region later produces a new event.
REQ-019 SHALL, on CONFLICT, abandon TRACK (return to LOCKED if a region is locked, else IDLE) and leave the locked region unchanged.
REQ-020 SHALL, in LOCKED on VALID(locked region), stay LOCKED without pushing.
REQ-021 SHALL write a push into the FIFO at the clock edge after the en cycle that completed acceptance; evt_valid rises after that edge when the queue was empty.
REQ-022 SHALL drive evt_valid = queue non-empty and evt_code = head entry, stable until popped.
REQ-023 SHALL pop on any edge where evt_valid and evt_ready are both 1.
REQ-024 SHALL, on push with queue full and no pop in the same cycle, discard the push and increment drop_count, saturating at 255.
REQ-025 SHALL, on push and pop in the same cycle, perform both (full queue stays full, no drop; empty queue cannot pop).
REQ-026 SHALL wrap read/write pointers modulo FIFO_DEPTH; fifo_full is registered-consistent with occupancy.

Reset
REQ-027 SHALL, while rst_n=0, force FSM=IDLE, hold_cnt=0, queue empty, evt_valid=0, evt_code=0, fifo_full=0, drop_count=0.
REQ-028 SHALL discard any in-progress TRACK or queued events on reset assertion mid-operation.

Configuration
REQ-029 SHALL honour macro REGION_HOLD_EN: defined -> HOLD_FRAMES persistence per REQ-016; undefined -> effective hold of 1, first VALID(i) accepting immediately (TRACK state unreachable).

Structure
REQ-030 SHALL place region index encoding, classification enum (VALID/NONE/CONFLICT) and FSM state encoding in shared package region_pkg.
REQ-031 SHALL implement the queue as sub-module region_event_fifo (parameterised depth, 2-bit data).

Verification
REQ-032 SHALL cover: REGION_HOLD_EN, evt_ready=1, three en strobes green_region=4'b0010 -> exactly one event, evt_code=1, evt_valid one edge after third strobe.
REQ-033 SHALL cover: strobes 0010,0010,0100,0100,0100 -> single event evt_code=2, none for green.
REQ-034 SHALL cover: locked on red, strobe 0000 then three strobes 0001 -> second event evt_code=0.
REQ-035 SHALL cover: evt_ready=0, six accepted region changes with FIFO_DEPTH=4 -> fifo_full=1, drop_count=2, queue drains in order.
REQ-036 SHALL cover: strobe 0110 while tracking blue -> candidate dropped, no event, locked region unchanged.
REQ-037 SHALL cover: rst_n low for one cycle with two events queued -> evt_valid=0, drop_count=0 immediately, no event after release until new acceptance.
